rtc_read_sequencer: RTL and testbench
=====================================

RTC_READ_SEQUENCER -- requirements
Module: rtc_read_sequencer

Interface
REQ-001 SHALL have parameter T_PH, default 10, meaning clock cycles per bus phase (legal range 1..255).
REQ-002 SHALL have parameter N_REGS, default 8, meaning the number of RTC registers read per burst; fixed at 8.
REQ-003 clk  in  1  system clock; all flops on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 tick  in  1  single-cycle burst request.
REQ-006 ad_in  in  8  data read back from the RTC multiplexed bus.
REQ-007 ad_out  out  8  address driven onto the RTC bus.
REQ-008 ad_oe  out  1  tristate enable for ad_out; the top level owns the tristate buffer.
REQ-009 cs_n, rd_n, wr_n, ad_n  out  1 each  RTC strobes, active-low; ad_n low selects the address phase.
REQ-010 busy  out  1  high from the first ADDR cycle through the last EMIT cycle.
REQ-011 inicioSecuencia  out  1  frames the byte stream consumed by Interfaz.
REQ-012 datoRTC  out  8  byte stream to Interfaz, one byte per clock.

Function
REQ-013 States: IDLE, ADDR, GAP1, READ, GAP2, EMIT_LEAD, EMIT; each bus state lasts exactly T_PH cycles, timed by a phase counter.
REQ-014 In IDLE, a tick sampled high at edge k SHALL enter ADDR at k+1 with register index 0.
REQ-015 A tick arriving while busy SHALL be ignored and SHALL NOT be queued.
REQ-016 ADDR: cs_n=0, wr_n=0, ad_n=0, ad_oe=1, ad_out=ADDR_TABLE[index].
REQ-017 GAP1 and GAP2: all strobes high, ad_oe=0.
REQ-018 READ: cs_n=0, rd_n=0, ad_n=1, ad_oe=0; ad_in is captured into buffer[index] on the last READ cycle.
REQ-019 After GAP2, the block returns to ADDR with index+1 if index<7; otherwise it goes to EMIT_LEAD.
REQ-020 ADDR_TABLE, in order: 0x21 seconds, 0x22 minutes, 0x23 hours, 0x24 date, 0x25 month, 0x26 year, 0x27 day, 0x28 week.
REQ-021 EMIT_LEAD: one cycle with inicioSecuencia=1, datoRTC=0x00. Its edge is k+1+32*T_PH.
REQ-022 EMIT: 8 cycles with inicioSecuencia=1 and datoRTC=buffer[0..7] in order, then return to IDLE with inicioSecuencia=0 and datoRTC=0x00.
REQ-023 wr_n and rd_n SHALL never be low in the same cycle; ad_oe SHALL be 1 only in ADDR.
REQ-024 The phase counter and index SHALL NOT wrap inside a burst; the index is 3 bits and stops at 7.
REQ-025 The buffer is held between bursts; it is overwritten only by READ captures.

Reset
REQ-026 While reset=0, the block SHALL immediately force state=IDLE, cs_n=rd_n=wr_n=ad_n=1, ad_oe=0, ad_out=0x00, busy=0, inicioSecuencia=0, datoRTC=0x00, counters=0, buffer=0x00.
REQ-027 Reset asserted mid-burst SHALL abort the burst with no partial EMIT; after deassertion, the block waits for a new tick.
REQ-028 Reset deassertion SHALL be synchronised by the integrator; the block needs no internal synchroniser.

Structure
REQ-029 A shared package rtc_pkg SHALL hold the state enum, N_REGS, and ADDR_TABLE constants.
REQ-030 The phase counter SHALL be a sub-module rtc_phase_timer, with inputs start and len and output done on the last cycle.
REQ-031 The top level of rtc_read_sequencer contains only the FSM, the index counter, the 8x8 buffer, and the output registers; all outputs are registered.

Verification
REQ-032 Basic burst: T_PH=10, RTC model returns {24,0,0,23,12,17,5,4}, tick at edge 100 -> ADDR at 101; EMIT_LEAD at 421; datoRTC=24,0,0,23,12,17,5,4 at edges 422..429; IDLE at 430.
REQ-033 Bus protocol check: ad_out sequence is 0x21..0x28; each strobe is low for exactly 10 cycles; no rd_n/wr_n overlap; ad_oe is high only while ad_n=0.
REQ-034 Tick while busy: second tick at edge 200 -> no effect; a single EMIT at 421..429 and exactly 8 READ phases.
REQ-035 Reset mid-burst: reset=0 at edge 250 -> all outputs are at reset values within the same cycle; no inicioSecuencia pulse; a new tick at 300 gives a full burst with EMIT_LEAD at 621.
REQ-036 Minimum timing: T_PH=1, tick at 10 -> EMIT_LEAD at 43, bytes at 44..51.
REQ-037 Back-to-back bursts: tick at the first IDLE cycle after EMIT -> a new ADDR on the next edge; the buffer is replaced only as each READ completes.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared state encoding and constants for the RTC read sequencer.
package rtc_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        GAP1      = 3'd2,
        READ      = 3'd3,
        GAP2      = 3'd4,
        EMIT_LEAD = 3'd5,
        EMIT      = 3'd6
    } rtc_state_t;

    localparam int N_REGS = 8;

    // Entry i is the RTC register address read into byte i of the burst:
    // seconds, minutes, hours, date, month, year, day, week.
    localparam logic [N_REGS-1:0][7:0] ADDR_TABLE = {
        8'h28, 8'h27, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21
    };

endpackage

// File: rtl/rtc_phase_timer.sv
// Bus phase timer: a pulse on start loads a phase of len cycles; done is high
// on the last cycle of that phase (and stays high while no phase is running).
module rtc_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] len,
    output logic       done
);

    logic [7:0] count;

    // Counts down to zero and holds there; never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 8'd0;
        end else if (start) begin
            count <= len - 8'd1;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count == 8'd0);

endmodule

// File: rtl/rtc_read_sequencer.sv
// Reads the eight RTC time registers over the multiplexed bus, then replays
// them as a framed byte stream (one lead byte plus eight data bytes).
module rtc_read_sequencer
    import rtc_pkg::*;
#(
    parameter int T_PH   = 10,
    parameter int N_REGS = rtc_pkg::N_REGS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n,
    output logic       busy,
    output logic       inicioSecuencia,
    output logic [7:0] datoRTC,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] LAST_IDX = 3'(N_REGS - 1);
    localparam logic [7:0] PH_LEN   = 8'(T_PH);

    rtc_state_t state, next_state;
    logic [2:0] idx, next_idx;
    logic       tick_q;
    logic       ph_start, ph_done, capture;
    logic [7:0] buffer [N_REGS];

    rtc_phase_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .start (ph_start),
        .len   (PH_LEN),
        .done  (ph_done)
    );

    // tick is a fire-and-forget request with no ready: it is honoured only
    // when sampled in IDLE, otherwise dropped (busy tells the requester why).
    always_comb begin
        next_state = state;
        next_idx   = idx;
        ph_start   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: if (tick_q) begin
                next_state = ADDR;
                next_idx   = 3'd0;
                ph_start   = 1'b1;
            end
            ADDR: if (ph_done) begin
                next_state = GAP1;
                ph_start   = 1'b1;
            end
            GAP1: if (ph_done) begin
                next_state = READ;
                ph_start   = 1'b1;
            end
            READ: if (ph_done) begin
                next_state = GAP2;
                ph_start   = 1'b1;
                capture    = 1'b1;
            end
            GAP2: if (ph_done) begin
                if (idx == LAST_IDX) begin
                    next_state = EMIT_LEAD;
                end else begin
                    next_state = ADDR;
                    next_idx   = idx + 3'd1;
                    ph_start   = 1'b1;
                end
            end
            EMIT_LEAD: begin
                next_state = EMIT;
                next_idx   = 3'd0;
            end
            EMIT: begin
                if (idx == LAST_IDX) begin
                    next_state = IDLE;
                    next_idx   = 3'd0;
                end else begin
                    next_idx = idx + 3'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the
    // registered state rather than trailing it by a cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            idx             <= 3'd0;
            tick_q          <= 1'b0;
            cs_n            <= 1'b1;
            rd_n            <= 1'b1;
            wr_n            <= 1'b1;
            ad_n            <= 1'b1;
            ad_oe           <= 1'b0;
            ad_out          <= 8'h00;
            busy            <= 1'b0;
            inicioSecuencia <= 1'b0;
            datoRTC         <= 8'h00;
            for (int i = 0; i < N_REGS; i++) buffer[i] <= 8'h00;
        end else begin
            state           <= next_state;
            idx             <= next_idx;
            tick_q          <= tick;
            if (capture) buffer[idx] <= ad_in;
            cs_n            <= !(next_state == ADDR || next_state == READ);
            wr_n            <= (next_state != ADDR);
            rd_n            <= (next_state != READ);
            ad_n            <= (next_state != ADDR);
            ad_oe           <= (next_state == ADDR);
            ad_out          <= (next_state == ADDR) ? ADDR_TABLE[next_idx] : 8'h00;
            busy            <= (next_state != IDLE);
            inicioSecuencia <= (next_state == EMIT_LEAD || next_state == EMIT);
            datoRTC         <= (next_state == EMIT) ? buffer[next_idx] : 8'h00;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Bench for rtc_read_sequencer: two instances (T_PH=10 and T_PH=1) share one
// stimulus stream and are compared every cycle against a timeline model.
module tb_rtc_read_sequencer;

    localparam int T0 = 10;
    localparam int T1 = 1;
    localparam int NB = 2;
    localparam logic [7:0] BASIC [8] = '{8'd24, 8'd0, 8'd0, 8'd23, 8'd12, 8'd17, 8'd5, 8'd4};

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    int base = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    logic [7:0] ad_in_v [NB];
    logic [7:0] ad_out_v [NB];
    logic [7:0] dato_v [NB];
    logic [2:0] dbg_v [NB];
    logic [NB-1:0] ad_oe_v, cs_n_v, rd_n_v, wr_n_v, ad_n_v, busy_v, ini_v;

    rtc_read_sequencer #(.T_PH(T0)) dut0 (
        .clk(clk), .reset(reset), .tick(tick), .ad_in(ad_in_v[0]),
        .ad_out(ad_out_v[0]), .ad_oe(ad_oe_v[0]), .cs_n(cs_n_v[0]), .rd_n(rd_n_v[0]),
        .wr_n(wr_n_v[0]), .ad_n(ad_n_v[0]), .busy(busy_v[0]),
        .inicioSecuencia(ini_v[0]), .datoRTC(dato_v[0]), .dbg_state(dbg_v[0])
    );

    rtc_read_sequencer #(.T_PH(T1)) dut1 (
        .clk(clk), .reset(reset), .tick(tick), .ad_in(ad_in_v[1]),
        .ad_out(ad_out_v[1]), .ad_oe(ad_oe_v[1]), .cs_n(cs_n_v[1]), .rd_n(rd_n_v[1]),
        .wr_n(wr_n_v[1]), .ad_n(ad_n_v[1]), .busy(busy_v[1]),
        .inicioSecuencia(ini_v[1]), .datoRTC(dato_v[1]), .dbg_state(dbg_v[1])
    );

    // RTC device model: latches the address phase, answers reads from rtc_mem
    logic [7:0] rtc_mem [8];
    logic [7:0] lat_addr [NB];
    logic [7:0] noise = 8'h5A;

    always @(posedge clk) begin
        #1 noise = 8'($urandom);
    end

    always @(negedge clk) begin
        for (int i = 0; i < NB; i++)
            if (!ad_n_v[i] && !wr_n_v[i] && ad_oe_v[i]) lat_addr[i] = ad_out_v[i];
    end

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            ad_in_v[i] = noise;
            if (!rd_n_v[i] && lat_addr[i] >= 8'h21 && lat_addr[i] <= 8'h28)
                ad_in_v[i] = rtc_mem[3'(lat_addr[i] - 8'h21)];
        end
    end

    // scoreboard counters
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d rel_edge %0d got %0d expected %0d", nm, i, edge_n - base, got, exp);
        end
    endtask

    function automatic int tph(input int i);
        return (i == 0) ? T0 : T1;
    endfunction

    // Behavioural model: a burst is a timeline of 32 bus phases of T cycles
    // (ADDR, GAP1, READ, GAP2 per register), one lead cycle, eight bytes.
    // kind: 0 idle, 1 addr, 2 gap1, 3 read, 4 gap2, 5 lead, 6 emit
    logic act [NB];
    int start_e [NB];
    logic [7:0] mbuf [NB][8];

    task automatic model_at(input int i, input int e, output int kind, output int r);
        int o;
        int t;
        t = tph(i);
        kind = 0;
        r = 0;
        if (act[i]) begin
            o = e - start_e[i];
            if (o >= 0 && o < 32 * t) begin
                kind = 1 + (o / t) % 4;
                r = o / (4 * t);
            end else if (o == 32 * t) begin
                kind = 5;
            end else if (o > 32 * t && o <= 32 * t + 8) begin
                kind = 6;
                r = o - 32 * t - 1;
            end
        end
    endtask

    // recorders for the hand-computed expectations
    int busy_rise [NB], busy_fall [NB], last_rise [NB], lead_e [NB], ini_rises [NB];
    int em_n [NB], em_first [NB], rd_cnt [NB], ad_cnt [NB];
    logic [7:0] em [NB][16];
    logic [7:0] adseq [NB][8];
    int run [NB][4];
    logic prev_busy [NB], prev_ini [NB], prev_rd [NB], prev_adn [NB];

    task automatic clear_rec();
        for (int i = 0; i < NB; i++) begin
            busy_rise[i] = -1; busy_fall[i] = -1; last_rise[i] = -1; lead_e[i] = -1;
            ini_rises[i] = 0; em_n[i] = 0; em_first[i] = -1; rd_cnt[i] = 0; ad_cnt[i] = 0;
        end
    endtask

    int m_kind, m_r, m_k2, m_r2, m_t, m_rel;
    logic [3:0] m_st;

    // compare process
    always @(negedge clk) begin
        for (int i = 0; i < NB; i++) begin
            m_t = tph(i);
            m_rel = edge_n - base;
            m_st = {ad_n_v[i], rd_n_v[i], wr_n_v[i], cs_n_v[i]};
            if (!reset) begin
                act[i] = 1'b0;
                for (int j = 0; j < 8; j++) mbuf[i][j] = 8'h00;
                for (int s = 0; s < 4; s++) run[i][s] = 0;
                chk("rst_strobes", i, m_st, 4'hF);
                chk("rst_busy", i, busy_v[i], 0);
                chk("rst_ini", i, ini_v[i], 0);
                chk("rst_dato", i, dato_v[i], 0);
                chk("rst_oe", i, ad_oe_v[i], 0);
            end else begin
                model_at(i, edge_n, m_kind, m_r);
                chk("cs_n", i, cs_n_v[i], (m_kind == 1 || m_kind == 3) ? 0 : 1);
                chk("wr_n", i, wr_n_v[i], (m_kind == 1) ? 0 : 1);
                chk("rd_n", i, rd_n_v[i], (m_kind == 3) ? 0 : 1);
                chk("ad_n", i, ad_n_v[i], (m_kind == 1) ? 0 : 1);
                chk("ad_oe", i, ad_oe_v[i], (m_kind == 1) ? 1 : 0);
                chk("busy", i, busy_v[i], (m_kind != 0) ? 1 : 0);
                chk("inicio", i, ini_v[i], (m_kind >= 5) ? 1 : 0);
                chk("dato", i, dato_v[i], (m_kind == 6) ? mbuf[i][m_r] : 8'h00);
                chk("dbg_idle", i, dbg_v[i] == rtc_pkg::IDLE, m_kind == 0);
                if (m_kind == 1) chk("ad_out", i, ad_out_v[i], 8'h21 + m_r);
                chk("no_overlap", i, !rd_n_v[i] && !wr_n_v[i], 0);
                chk("oe_only_addr", i, ad_oe_v[i] && ad_n_v[i], 0);
                if (m_kind == 3 && ((edge_n - start_e[i]) % m_t) == m_t - 1)
                    mbuf[i][m_r] = rtc_mem[m_r];
                model_at(i, edge_n + 1, m_k2, m_r2);
                if (tick && m_k2 == 0) begin
                    act[i] = 1'b1;
                    start_e[i] = edge_n + 2;
                end
                for (int s = 0; s < 4; s++) begin
                    if (!m_st[s]) run[i][s]++;
                    else if (run[i][s] > 0) begin
                        chk("low_len", i, run[i][s], m_t);
                        run[i][s] = 0;
                    end
                end
                if (busy_v[i] && !prev_busy[i]) begin
                    if (busy_rise[i] < 0) busy_rise[i] = m_rel;
                    last_rise[i] = m_rel;
                end
                if (!busy_v[i] && prev_busy[i] && busy_fall[i] < 0) busy_fall[i] = m_rel;
                if (ini_v[i] && !prev_ini[i]) begin
                    ini_rises[i]++;
                    if (lead_e[i] < 0) lead_e[i] = m_rel;
                end else if (ini_v[i]) begin
                    if (em_first[i] < 0) em_first[i] = m_rel;
                    if (em_n[i] < 16) em[i][em_n[i]] = dato_v[i];
                    em_n[i]++;
                end
                if (!rd_n_v[i] && prev_rd[i]) rd_cnt[i]++;
                if (!ad_n_v[i] && prev_adn[i]) begin
                    if (ad_cnt[i] < 8) adseq[i][ad_cnt[i]] = ad_out_v[i];
                    ad_cnt[i]++;
                end
            end
            prev_busy[i] = busy_v[i];
            prev_ini[i] = ini_v[i];
            prev_rd[i] = rd_n_v[i];
            prev_adn[i] = ad_n_v[i];
        end
    end

    // driver tasks
    task automatic wait_rel(input int n);
        while (edge_n < base + n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_at(input int k);
        wait_rel(k - 1);
        tick = 1'b1;
        wait_rel(k);
        tick = 1'b0;
    endtask

    task automatic check_reset_now();
        for (int i = 0; i < NB; i++) begin
            chk("now_strobes", i, {ad_n_v[i], rd_n_v[i], wr_n_v[i], cs_n_v[i]}, 4'hF);
            chk("now_oe", i, ad_oe_v[i], 0);
            chk("now_ad_out", i, ad_out_v[i], 8'h00);
            chk("now_busy", i, busy_v[i], 0);
            chk("now_ini", i, ini_v[i], 0);
            chk("now_dato", i, dato_v[i], 8'h00);
            chk("now_state", i, dbg_v[i], rtc_pkg::IDLE);
        end
    endtask

    task automatic new_scenario();
        @(posedge clk);
        #3;
        reset = 1'b0;
        tick = 1'b0;
        #1 check_reset_now();
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        base = edge_n;
        clear_rec();
    endtask

    task automatic load_mem(input logic [7:0] d [8]);
        for (int j = 0; j < 8; j++) rtc_mem[j] = d[j];
    endtask

    task automatic report();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog time limit reached");
        report();
        $finish;
    end

    initial begin
        for (int i = 0; i < NB; i++) lat_addr[i] = 8'h00;
        load_mem(BASIC);

        // basic burst and bus protocol
        new_scenario();
        tick_at(100);
        wait_rel(440);
        chk("s1_busy_rise", 0, busy_rise[0], 101);
        chk("s1_lead", 0, lead_e[0], 421);
        chk("s1_first_byte", 0, em_first[0], 422);
        chk("s1_idle", 0, busy_fall[0], 430);
        chk("s1_nbytes", 0, em_n[0], 8);
        for (int j = 0; j < 8; j++) chk("s1_byte", 0, em[0][j], BASIC[j]);
        chk("s1_reads", 0, rd_cnt[0], 8);
        chk("s1_addrs", 0, ad_cnt[0], 8);
        for (int j = 0; j < 8; j++) chk("s1_ad_seq", 0, adseq[0][j], 8'h21 + j);
        chk("s1_lead_t1", 1, lead_e[1], 133);

        // tick while busy is dropped
        new_scenario();
        tick_at(100);
        tick_at(200);
        wait_rel(440);
        chk("s2_lead", 0, lead_e[0], 421);
        chk("s2_one_emit", 0, ini_rises[0], 1);
        chk("s2_reads", 0, rd_cnt[0], 8);
        chk("s2_idle", 0, busy_fall[0], 430);

        // reset mid-burst, then a fresh burst
        new_scenario();
        for (int j = 0; j < 8; j++) rtc_mem[j] = 8'($urandom);
        tick_at(100);
        wait_rel(250);
        #2;
        reset = 1'b0;
        #1 check_reset_now();
        wait_rel(253);
        #2;
        reset = 1'b1;
        tick_at(300);
        wait_rel(650);
        chk("s3_lead", 0, lead_e[0], 621);
        chk("s3_one_emit", 0, ini_rises[0], 1);

        // minimum timing, then back-to-back on T_PH=1
        new_scenario();
        load_mem(BASIC);
        tick_at(10);
        wait_rel(45);
        for (int j = 0; j < 8; j++) rtc_mem[j] = 8'($urandom);
        tick_at(52);
        wait_rel(70);
        rtc_mem[7] = 8'hC3;
        wait_rel(460);
        chk("s4_lead", 1, lead_e[1], 43);
        chk("s4_first_byte", 1, em_first[1], 44);
        chk("s4_idle", 1, busy_fall[1], 52);
        for (int j = 0; j < 8; j++) chk("s4_byte", 1, em[1][j], BASIC[j]);
        chk("s5_b2b_addr", 1, last_rise[1], 53);
        chk("s5_two_emits", 1, ini_rises[1], 2);

        // randomized traffic
        new_scenario();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            tick = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) rtc_mem[$urandom_range(0, 7)] = 8'($urandom);
            if ($urandom_range(0, 999) == 0) begin
                tick = 1'b0;
                #2;
                reset = 1'b0;
                #1 check_reset_now();
                repeat (2) @(posedge clk);
                #3;
                reset = 1'b1;
            end
        end
        tick = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        report();
        $finish;
    end

endmodule
